// File: rtl/fu_complete_arbiter_pkg.sv
// Shared types for the FU completion arbiter.
//   fu_complete_packet_t / FU_COMPLETE_PACKET : result packet from one function unit
//   CDB_PACKET                                : the CDB_W broadcast slots seen by ROB/RS/map table
//   NUM_FU_DEF / CDB_W_DEF                    : default unit count and CDB slot count
package fu_complete_arbiter_pkg;

  localparam int NUM_FU_DEF = 4;
  localparam int CDB_W_DEF  = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [5:0]  dest_prn;
    logic [31:0] dest_value;
    logic        take_branch;
  } fu_complete_packet_t;

  typedef fu_complete_packet_t FU_COMPLETE_PACKET;

  typedef fu_complete_packet_t [CDB_W_DEF-1:0] CDB_PACKET;

endpackage

// File: rtl/rr_multi_grant.sv
// Rotating-priority multi-grant encoder (pure combinational).
// Scans req starting at ptr, wrapping modulo NUM_FU, and grants the first
// CDB_W requesters.
//   req      : per-FU request
//   ptr      : scan start index
//   grant    : per-FU grant vector
//   slot_idx : FU index placed in each slot (slot 0 = first in scan order)
//   slot_vld : slot carries a grant
//   last_idx : last granted index (only meaningful when count != 0)
//   count    : number of grants
module rr_multi_grant #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  localparam int PTR_W = $clog2(NUM_FU),
  localparam int CNT_W = $clog2(CDB_W + 1)
) (
  input  logic [NUM_FU-1:0]            req,
  input  logic [PTR_W-1:0]             ptr,
  output logic [NUM_FU-1:0]            grant,
  output logic [CDB_W-1:0][PTR_W-1:0]  slot_idx,
  output logic [CDB_W-1:0]             slot_vld,
  output logic [PTR_W-1:0]             last_idx,
  output logic [CNT_W-1:0]             count
);

  always_comb begin
    int idx;
    int n;
    idx      = 0;
    n        = 0;
    grant    = '0;
    slot_idx = '0;
    slot_vld = '0;
    last_idx = ptr;
    count    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      // Rotated index without a modulo operator so non-power-of-2 NUM_FU works.
      idx = int'(ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (req[PTR_W'(idx)] && (n < CDB_W)) begin
        grant[PTR_W'(idx)] = 1'b1;
        // Slot index is compared against constants so every select is static.
        for (int s = 0; s < CDB_W; s++) begin
          if (n == s) begin
            slot_idx[s] = PTR_W'(idx);
            slot_vld[s] = 1'b1;
          end
        end
        last_idx = PTR_W'(idx);
        n        = n + 1;
      end
    end
    count = CNT_W'(n);
  end

endmodule

// File: rtl/fu_complete_arbiter.sv
// Arbitrates function-unit completion requests onto CDB_W broadcast slots.
// Losing units see complete_stall in the same cycle and hold their packet;
// winners appear on the registered CDB one cycle later. The round-robin
// pointer moves past the last winner, so every unit is served in bounded time.
//   clock, reset     : clock, synchronous active-high reset
//   squash           : flush; suppresses grants and stalls this cycle
//   want_to_complete : per-FU request
//   fu_packet_in     : per-FU result packet
//   complete_stall   : per-FU stall (combinational)
//   cdb_packet_out   : registered CDB slots
//   cdb_valid        : per-slot valid
//   grant_count      : registered number of valid slots
module fu_complete_arbiter
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int CDB_W  = CDB_W_DEF,
  localparam int PTR_W = $clog2(NUM_FU),
  localparam int CNT_W = $clog2(CDB_W + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                squash,
  input  logic [NUM_FU-1:0]                   want_to_complete,
  input  fu_complete_packet_t [NUM_FU-1:0]    fu_packet_in,
  output logic [NUM_FU-1:0]                   complete_stall,
  output fu_complete_packet_t [CDB_W-1:0]     cdb_packet_out,
  output logic [CDB_W-1:0]                    cdb_valid,
  output logic [CNT_W-1:0]                    grant_count
);

  logic [PTR_W-1:0]             rr_ptr;
  logic                         block;
  logic [NUM_FU-1:0]            req;
  logic [NUM_FU-1:0]            grant;
  logic [CDB_W-1:0][PTR_W-1:0]  slot_idx;
  logic [CDB_W-1:0]             slot_vld;
  logic [PTR_W-1:0]             last_idx;
  logic [CNT_W-1:0]             count;
  fu_complete_packet_t [CDB_W-1:0] slot_pkt;

  // Reset and squash both mean "nobody completes": the FUs are being flushed,
  // so they must not be told to hold either.
  assign block = reset | squash;
  assign req   = block ? '0 : want_to_complete;

  rr_multi_grant #(
    .NUM_FU (NUM_FU),
    .CDB_W  (CDB_W)
  ) u_grant (
    .req      (req),
    .ptr      (rr_ptr),
    .grant    (grant),
    .slot_idx (slot_idx),
    .slot_vld (slot_vld),
    .last_idx (last_idx),
    .count    (count)
  );

  assign complete_stall = block ? '0 : (want_to_complete & ~grant);

  // Packet is copied verbatim except its valid bit tracks the slot valid.
  always_comb begin
    slot_pkt = '0;
    for (int s = 0; s < CDB_W; s++) begin
      if (slot_vld[s]) begin
        slot_pkt[s]       = fu_packet_in[slot_idx[s]];
        slot_pkt[s].valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr         <= '0;
      cdb_valid      <= '0;
      cdb_packet_out <= '0;
      grant_count    <= '0;
    end else begin
      cdb_valid      <= slot_vld;
      cdb_packet_out <= slot_pkt;
      grant_count    <= count;
      if (count != '0)
        rr_ptr <= (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Scoreboard bench for fu_complete_arbiter: the driver computes the expected
// CDB contents from a rotation-order list of requesters and queues them; the
// monitor pops one entry per cycle and compares against the registered outputs.
module tb_fu_complete_arbiter;
  import fu_complete_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int W     = 2;
  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = $clog2(W + 1);
  localparam int BOUND = (N + W - 1) / W - 1;  // max consecutive stalls

  logic                          clock = 1'b0;
  logic                          reset = 1'b1;
  logic                          squash = 1'b0;
  logic [N-1:0]                  want_to_complete = '0;
  fu_complete_packet_t [N-1:0]   fu_packet_in = '0;
  logic [N-1:0]                  complete_stall;
  fu_complete_packet_t [W-1:0]   cdb_packet_out;
  logic [W-1:0]                  cdb_valid;
  logic [CNT_W-1:0]              grant_count;

  fu_complete_arbiter #(.NUM_FU(N), .CDB_W(W)) dut (
    .clock            (clock),
    .reset            (reset),
    .squash           (squash),
    .want_to_complete (want_to_complete),
    .fu_packet_in     (fu_packet_in),
    .complete_stall   (complete_stall),
    .cdb_packet_out   (cdb_packet_out),
    .cdb_valid        (cdb_valid),
    .grant_count      (grant_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0]                vld;
    fu_complete_packet_t [W-1:0] pkt;
    int                          cnt;
    int                          ptr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mptr   = 0;
  int   starve[N];

  // One cycle of stimulus plus the model's view of it. dv >= 0 forces every
  // packet's dest_value so directed cases can use readable data.
  task automatic cycle(input logic r, input logic s, input logic [N-1:0] w, input int dv);
    int           ord[$];
    int           ng;
    logic [N-1:0] gmask;
    logic [N-1:0] exp_stall;
    exp_t         e;
    @(posedge clock);
    #1;
    reset            = r;
    squash           = s;
    want_to_complete = w;
    for (int i = 0; i < N; i++) begin
      fu_packet_in[i].valid       = 1'($urandom);
      fu_packet_in[i].rob_idx     = 5'($urandom);
      fu_packet_in[i].dest_prn    = 6'($urandom);
      fu_packet_in[i].dest_value  = (dv >= 0) ? 32'(dv) : $urandom;
      fu_packet_in[i].take_branch = 1'($urandom);
    end
    @(negedge clock);
    // Requesters listed in priority order from the model pointer.
    if (!r && !s)
      for (int d = 0; d < N; d++)
        if (w[(mptr + d) % N]) ord.push_back((mptr + d) % N);
    ng    = (ord.size() < W) ? ord.size() : W;
    gmask = '0;
    for (int k = 0; k < ng; k++) gmask[ord[k]] = 1'b1;
    exp_stall = (r || s) ? '0 : (w & ~gmask);
    checks++;
    if (complete_stall !== exp_stall) begin
      errors++;
      $display("FAIL stall t=%0t got=%b exp=%b", $time, complete_stall, exp_stall);
    end
    e.vld = '0;
    e.pkt = '0;
    for (int k = 0; k < ng; k++) begin
      e.vld[k]       = 1'b1;
      e.pkt[k]       = fu_packet_in[ord[k]];
      e.pkt[k].valid = 1'b1;
    end
    e.cnt = ng;
    if (r)           mptr = 0;
    else if (ng > 0) mptr = (ord[ng-1] + 1) % N;
    e.ptr = mptr;
    q.push_back(e);
    // Starvation bound, measured on the DUT's own stall outputs.
    for (int i = 0; i < N; i++) begin
      starve[i] = complete_stall[i] ? starve[i] + 1 : 0;
      if (complete_stall[i]) begin
        checks++;
        if (starve[i] > BOUND) begin
          errors++;
          $display("FAIL starve fu=%0d stalls=%0d max=%0d", i, starve[i], BOUND);
        end
      end
    end
  endtask

  // Monitor: registered outputs after each edge correspond to the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (cdb_valid !== e.vld) begin
          errors++;
          $display("FAIL cdb_valid t=%0t got=%b exp=%b", $time, cdb_valid, e.vld);
        end
        checks++;
        if (grant_count !== CNT_W'(e.cnt)) begin
          errors++;
          $display("FAIL grant_count t=%0t got=%0d exp=%0d", $time, grant_count, e.cnt);
        end
        checks++;
        if (dut.rr_ptr !== PTR_W'(e.ptr)) begin
          errors++;
          $display("FAIL rr_ptr t=%0t got=%0d exp=%0d", $time, dut.rr_ptr, e.ptr);
        end
        for (int s = 0; s < W; s++) begin
          checks++;
          if (cdb_packet_out[s] !== e.pkt[s]) begin
            errors++;
            $display("FAIL slot%0d t=%0t got=%h exp=%h", s, $time, cdb_packet_out[s], e.pkt[s]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) starve[i] = 0;
    // Reset, then FU1 alone with 0x8.
    cycle(1, 0, 4'b0000, -1);
    cycle(1, 0, 4'b0000, -1);
    cycle(0, 0, 4'b0010, 8);
    cycle(0, 0, 4'b0000, -1);
    // From ptr 0, everyone requests twice.
    cycle(1, 0, 4'b0000, -1);
    cycle(0, 0, 4'b1111, -1);
    cycle(0, 0, 4'b1111, -1);
    // Walk ptr to 3, then wrap with {0,3}.
    cycle(0, 0, 4'b0111, -1);
    cycle(0, 0, 4'b0100, -1);
    cycle(0, 0, 4'b1001, -1);
    // Sustained full load.
    for (int k = 0; k < 8; k++) cycle(0, 0, 4'b1111, -1);
    // Squash with 3 requesters, then a normal cycle.
    cycle(0, 0, 4'b1011, -1);
    cycle(0, 1, 4'b1011, -1);
    cycle(0, 0, 4'b1011, -1);
    // Reset mid-stream.
    cycle(0, 0, 4'b1111, -1);
    cycle(1, 0, 4'b1111, -1);
    cycle(0, 0, 4'b1111, -1);
    // Random traffic.
    for (int k = 0; k < 2000; k++)
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            4'($urandom), -1);
    cycle(0, 0, 4'b0000, -1);
    repeat (3) @(posedge clock);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
